// File: rtl/dem_tan_so.sv
// Gated frequency counter with a free-running period meter on an asynchronous input.
// The gate window length and counter width are set by the parameters.
`timescale 1ns/1ps
module dem_tan_so #(
  parameter int unsigned GATE_CYCLES = 50000000,
  parameter int unsigned CNT_W       = 27
) (
  input  logic             clki,
  input  logic             rst_n,
  input  logic             sig_in,
  input  logic             start,
  input  logic             continuous,
  output logic [CNT_W-1:0] freq_out,
  output logic [CNT_W-1:0] period_out,
  output logic             valid,
  output logic             busy,
  output logic             ovf
);

  // Gate counter is sized from GATE_CYCLES so that a narrow CNT_W never truncates the window.
  localparam int unsigned      GATE_W    = (GATE_CYCLES > 1) ? $clog2(GATE_CYCLES) : 1;
  localparam logic [GATE_W-1:0] GATE_LAST = GATE_W'(GATE_CYCLES - 1);
  localparam logic [GATE_W-1:0] GATE_ONE  = GATE_W'(1);
  localparam logic [CNT_W-1:0]  CNT_MAX   = '1;
  localparam logic [CNT_W-1:0]  CNT_ONE   = CNT_W'(1);

  typedef enum logic [1:0] {
    IDLE,
    GATE,
    DONE
  } state_t;

  state_t             state_q, state_d;
  logic               s1_q, s2_q, s3_q;
  logic               sig_edge;
  logic [GATE_W-1:0]  gate_cnt_q, gate_cnt_d;
  logic [CNT_W-1:0]   edge_cnt_q, edge_cnt_d;
  logic               ovf_q, ovf_d;
  logic [CNT_W-1:0]   freq_q, freq_d;
  logic               valid_q, valid_d;
  logic [CNT_W-1:0]   per_cnt_q, per_cnt_d;
  logic [CNT_W-1:0]   per_inc;
  logic [CNT_W-1:0]   period_q, period_d;
  logic               seen_q, seen_d;

  assign sig_edge = s2_q & ~s3_q;
  assign per_inc  = (per_cnt_q == CNT_MAX) ? CNT_MAX : (per_cnt_q + CNT_ONE);

  always_comb begin
    state_d    = state_q;
    gate_cnt_d = gate_cnt_q;
    edge_cnt_d = edge_cnt_q;
    ovf_d      = ovf_q;
    freq_d     = freq_q;
    valid_d    = 1'b0;
    per_cnt_d  = per_cnt_q;
    period_d   = period_q;
    seen_d     = seen_q;

    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d    = GATE;
          gate_cnt_d = '0;
          edge_cnt_d = '0;
          ovf_d      = 1'b0;
        end
      end
      GATE: begin
        gate_cnt_d = gate_cnt_q + GATE_ONE;
        if (sig_edge) begin
          if (edge_cnt_q == CNT_MAX) begin
            ovf_d = 1'b1;
          end else begin
            edge_cnt_d = edge_cnt_q + CNT_ONE;
          end
        end
        if (gate_cnt_q == GATE_LAST) begin
          state_d = DONE;
        end
      end
      DONE: begin
        freq_d  = edge_cnt_q;
        valid_d = 1'b1;
        if (continuous) begin
          state_d    = GATE;
          gate_cnt_d = '0;
          edge_cnt_d = '0;
          ovf_d      = 1'b0;
        end else begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    // Period meter runs independently of the gate FSM.
    if (sig_edge) begin
      if (seen_q) begin
        period_d = per_inc;
      end
      per_cnt_d = '0;
      seen_d    = 1'b1;
    end else begin
      per_cnt_d = per_inc;
    end
  end

  always_ff @(posedge clki) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      s1_q       <= 1'b0;
      s2_q       <= 1'b0;
      s3_q       <= 1'b0;
      gate_cnt_q <= '0;
      edge_cnt_q <= '0;
      ovf_q      <= 1'b0;
      freq_q     <= '0;
      valid_q    <= 1'b0;
      per_cnt_q  <= '0;
      period_q   <= '0;
      seen_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      s1_q       <= sig_in;
      s2_q       <= s1_q;
      s3_q       <= s2_q;
      gate_cnt_q <= gate_cnt_d;
      edge_cnt_q <= edge_cnt_d;
      ovf_q      <= ovf_d;
      freq_q     <= freq_d;
      valid_q    <= valid_d;
      per_cnt_q  <= per_cnt_d;
      period_q   <= period_d;
      seen_q     <= seen_d;
    end
  end

  assign freq_out   = freq_q;
  assign period_out = period_q;
  assign valid      = valid_q;
  assign busy       = (state_q == GATE);
  assign ovf        = ovf_q;

endmodule

// File: tb/tb_dem_tan_so.sv
// Directed bench for dem_tan_so: two instances (CNT_W=8 and CNT_W=4) share all inputs.
`timescale 1ns/1ps
module tb_dem_tan_so;

  logic       clk = 1'b0;
  logic       rst_n, start, cont, man_sig, gen_en;
  logic       sig;
  int unsigned gen_per;
  int unsigned ph;
  logic [7:0] f8, p8;
  logic [3:0] f4, p4;
  logic       v8, b8, o8, v4, b4, o4;

  int unsigned n_cmp = 0;
  int unsigned n_err = 0;

  always #5 clk = ~clk;

  always_ff @(posedge clk) begin
    if (ph + 1 >= gen_per) ph <= 0;
    else ph <= ph + 1;
  end
  assign sig = gen_en ? (ph < gen_per / 2) : man_sig;

  dem_tan_so #(.GATE_CYCLES(100), .CNT_W(8)) u8 (
    .clki(clk), .rst_n(rst_n), .sig_in(sig), .start(start), .continuous(cont),
    .freq_out(f8), .period_out(p8), .valid(v8), .busy(b8), .ovf(o8));

  dem_tan_so #(.GATE_CYCLES(100), .CNT_W(4)) u4 (
    .clki(clk), .rst_n(rst_n), .sig_in(sig), .start(start), .continuous(cont),
    .freq_out(f4), .period_out(p4), .valid(v4), .busy(b4), .ovf(o4));

  typedef struct {
    int unsigned per;
    int unsigned f8;
    int unsigned p8;
    int unsigned f4;
    int unsigned p4;
    bit          o4;
  } vec_t;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  // Wait up to 'lim' cycles for valid on the 8-bit instance; returns cycles waited.
  task automatic wait_valid(input string nm, input int unsigned lim, output int unsigned lat);
    bit got = 0;
    lat = 0;
    while (!got && lat < lim) begin
      tick();
      lat++;
      if (v8) got = 1;
    end
    if (!got) chk({nm, "_valid_timeout"}, 0, 1);
  endtask

  // Single window: checks latency, busy length and one-cycle valid.
  task automatic run_window(input string nm, input bit poke);
    int unsigned lat = 0;
    int unsigned bcnt = 0;
    bit got = 0;
    start = 1'b1;
    tick();
    start = 1'b0;
    if (b8) bcnt++;
    while (!got && lat < 200) begin
      tick();
      lat++;
      start = (poke && lat == 30);
      if (b8) bcnt++;
      if (v8) got = 1;
    end
    start = 1'b0;
    chk({nm, "_latency"}, lat, 101);
    chk({nm, "_busy_len"}, bcnt, 100);
    chk({nm, "_valid4"}, v4, 1);
    tick();
    chk({nm, "_valid_pulse"}, v8, 0);
  endtask

  vec_t vt[7];
  int unsigned lat;
  int unsigned fa, fb;
  int unsigned vseen;

  initial begin
    vt[0] = '{per: 10,  f8: 10, p8: 10,  f4: 10, p4: 10, o4: 1'b0};
    vt[1] = '{per: 4,   f8: 25, p8: 4,   f4: 15, p4: 4,  o4: 1'b1};
    vt[2] = '{per: 5,   f8: 20, p8: 5,   f4: 15, p4: 5,  o4: 1'b1};
    vt[3] = '{per: 20,  f8: 5,  p8: 20,  f4: 5,  p4: 15, o4: 1'b0};
    vt[4] = '{per: 2,   f8: 50, p8: 2,   f4: 15, p4: 2,  o4: 1'b1};
    vt[5] = '{per: 25,  f8: 4,  p8: 25,  f4: 4,  p4: 15, o4: 1'b0};
    vt[6] = '{per: 100, f8: 1,  p8: 100, f4: 1,  p4: 15, o4: 1'b0};

    rst_n = 1'b0; start = 1'b0; cont = 1'b0; man_sig = 1'b0;
    gen_en = 1'b1; gen_per = 10;
    repeat (3) tick();
    chk("rst_freq8", f8, 0);
    chk("rst_period8", p8, 0);
    chk("rst_valid8", v8, 0);
    chk("rst_busy8", b8, 0);
    chk("rst_ovf8", o8, 0);
    chk("rst_freq4", f4, 0);
    chk("rst_ovf4", o4, 0);
    rst_n = 1'b1;

    for (int i = 0; i < 7; i++) begin
      gen_per = vt[i].per;
      repeat (2 * vt[i].per + 5) tick();
      run_window($sformatf("vec%0d", i), 1'b0);
      chk($sformatf("vec%0d_freq8", i), f8, vt[i].f8);
      chk($sformatf("vec%0d_period8", i), p8, vt[i].p8);
      chk($sformatf("vec%0d_ovf8", i), o8, 0);
      chk($sformatf("vec%0d_freq4", i), f4, vt[i].f4);
      chk($sformatf("vec%0d_period4", i), p4, vt[i].p4);
      chk($sformatf("vec%0d_ovf4", i), o4, vt[i].o4);
    end

    // start re-asserted mid-window must not restart it
    gen_per = 10;
    repeat (25) tick();
    run_window("restart_ignored", 1'b1);
    chk("restart_freq8", f8, 10);

    // sticky ovf holds in IDLE and clears when the next window starts
    gen_per = 2;
    repeat (10) tick();
    run_window("ovf_win", 1'b0);
    repeat (5) tick();
    chk("ovf_sticky", o4, 1);
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("ovf_cleared", o4, 0);
    wait_valid("ovf_again", 200, lat);
    chk("ovf_reset_again", o4, 1);
    chk("ovf_freq4", f4, 15);

    // continuous mode: back-to-back windows
    gen_per = 4;
    repeat (15) tick();
    cont = 1'b1;
    start = 1'b1;
    tick();
    start = 1'b0;
    wait_valid("cont_first", 200, lat);
    chk("cont_first_lat", lat, 101);
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("cont%0d_busy", k), b8, 1);
      wait_valid($sformatf("cont%0d", k), 200, lat);
      chk($sformatf("cont%0d_interval", k), lat, 101);
      chk($sformatf("cont%0d_freq8", k), f8, 25);
    end
    cont = 1'b0;
    wait_valid("cont_last", 200, lat);
    chk("cont_last_interval", lat, 101);
    tick();
    chk("cont_stop_busy", b8, 0);

    // reset mid-window aborts with no valid pulse
    gen_per = 10;
    repeat (25) tick();
    start = 1'b1;
    tick();
    start = 1'b0;
    vseen = 0;
    repeat (50) begin
      tick();
      if (v8) vseen++;
    end
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    chk("midrst_busy", b8, 0);
    chk("midrst_freq", f8, 0);
    chk("midrst_period", p8, 0);
    repeat (60) begin
      tick();
      if (v8) vseen++;
    end
    chk("midrst_no_valid", vseen, 0);
    run_window("after_rst", 1'b0);
    chk("after_rst_freq8", f8, 10);
    chk("after_rst_period8", p8, 10);

    // single edge landing in the last GATE cycle vs. the DONE cycle
    gen_en = 1'b0;
    man_sig = 1'b0;
    repeat (5) tick();
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (97) tick();
    man_sig = 1'b1;
    wait_valid("edge_last", 10, lat);
    fa = f8;
    chk("edge_last_freq", f8, 1);
    man_sig = 1'b0;
    repeat (5) tick();
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (98) tick();
    man_sig = 1'b1;
    wait_valid("edge_done", 10, lat);
    fb = f8;
    chk("edge_done_freq", f8, 0);
    chk("edge_diff", fa - fb, 1);
    man_sig = 1'b0;

    // first edge after reset leaves period_out at 0; second edge 37 cycles later
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    repeat (5) tick();
    man_sig = 1'b1;
    repeat (3) tick();
    chk("first_edge_period", p8, 0);
    man_sig = 1'b0;
    repeat (34) tick();
    man_sig = 1'b1;
    repeat (3) tick();
    chk("period37_8", p8, 37);
    chk("period37_4", p4, 15);
    man_sig = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/dem_tan_so.md
DEM_TAN_SO -- requirements
Module: dem_tan_so

Interface
REQ-001 The block SHALL have parameter GATE_CYCLES, default 50000000, meaning gate window length in clki cycles (1 s at 50 MHz).
REQ-002 The block SHALL have parameter CNT_W, default 27, meaning width of all counters and result outputs.
REQ-003 The block SHALL have port clki, input, 1, meaning the single system clock; all logic on its rising edge.
REQ-004 The block SHALL have port rst_n, input, 1; reset is synchronous and active-low.
REQ-005 The block SHALL have port sig_in, input, 1, meaning the asynchronous signal to measure (e.g. a divided clock).
REQ-006 The block SHALL have port start, input, 1, meaning a request to begin a gate window; sampled only in IDLE.
REQ-007 The block SHALL have port continuous, input, 1, meaning auto-restart a new window after each result; sampled in DONE.
REQ-008 The block SHALL have port freq_out, output, CNT_W, meaning the rising-edge count of the last completed window.
REQ-009 The block SHALL have port period_out, output, CNT_W, meaning clki cycles between the two most recent sig_in rising edges.
REQ-010 The block SHALL have port valid, output, 1, meaning a one-cycle pulse when freq_out updates.
REQ-011 The block SHALL have port busy, output, 1, meaning high while in GATE.
REQ-012 The block SHALL have port ovf, output, 1, meaning an edge count saturated during the current or last window; sticky.

Function
REQ-013 sig_in SHALL pass a 2-flop synchronizer (s1, s2) plus a history flop s3; edge = s2 & ~s3.
REQ-014 A sig_in rise meeting setup before clock edge N SHALL produce edge high in exactly the cycle after edge N+1 (2-cycle latency).
REQ-015 The FSM SHALL have states IDLE, GATE, DONE; reset state IDLE.
REQ-016 IDLE: start=1 -> GATE next cycle, with gate_cnt=0, edge_cnt=0, ovf=0; start=0 -> stay.
REQ-017 GATE: gate_cnt SHALL increment every cycle; edge_cnt SHALL increment in every cycle where edge=1.
REQ-018 GATE SHALL last exactly GATE_CYCLES cycles; at gate_cnt==GATE_CYCLES-1 -> DONE, and an edge in that final cycle SHALL be counted.
REQ-019 start during GATE or DONE SHALL be ignored; the window is not restarted.
REQ-020 edge_cnt SHALL saturate at 2^CNT_W-1; an edge arriving at saturation SHALL set ovf, which holds until the next window starts.
REQ-021 DONE SHALL last one cycle: freq_out <= edge_cnt, valid=1; continuous=1 -> GATE with counters cleared (no dead cycle beyond DONE), else -> IDLE.
REQ-022 An edge occurring during the DONE cycle or in IDLE SHALL NOT be counted in any window.
REQ-023 freq_out SHALL hold its value until the next DONE.
REQ-024 Period measurement SHALL run in all states: per_cnt increments each cycle, saturating at 2^CNT_W-1.
REQ-025 On edge: if a prior edge has been seen since reset, period_out <= per_cnt+1 (saturating); per_cnt <= 0; set the seen-flag.
REQ-026 The first edge after reset SHALL NOT update period_out.
REQ-027 period_out SHALL equal the exact sig_in period in clki cycles for a clean periodic input (e.g. 10 for a 10-cycle period).

Reset
REQ-028 rst_n=0 at a clki edge SHALL force: state IDLE; freq_out, period_out, gate_cnt, edge_cnt, per_cnt, seen-flag = 0; valid, busy, ovf = 0; s1, s2, s3 = 0.
REQ-029 Reset mid-GATE SHALL abort the window with no valid pulse, and freq_out SHALL read 0 afterward.
REQ-030 No output SHALL be X after the first reset cycle.

Verification (GATE_CYCLES=100, CNT_W=8)
REQ-031 sig_in period 10 (5 high/5 low), single start -> one valid pulse 101 cycles after start, freq_out=10, busy high for 100 cycles, period_out=10.
REQ-032 continuous=1, sig_in period 4 -> valid pulses every 101 cycles, each freq_out=25, no gaps.
REQ-033 sig_in toggling every cycle with CNT_W=4 -> freq_out=15, ovf=1; next start clears ovf to 0.
REQ-034 rst_n=0 at gate_cnt=50 -> no valid pulse; busy=0, freq_out=0 next cycle; new start -> normal result.
REQ-035 Edge timed into the final GATE cycle is counted; edge timed into the DONE cycle is not (freq_out differs by exactly 1 between the two cases).
REQ-036 First sig_in rise after reset -> period_out stays 0; second rise 37 cycles later -> period_out=37.
